// File: rtl/msf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : msf_pkg
// Description : Shared types, constants and width helper for the MSF
//               level-accumulation sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package msf_pkg;

    localparam int MSF_SECS_PER_MIN = 60;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CALC  = 3'd3,
        ST_WRITE = 3'd4
    } msf_state_t;

    // Smallest address width able to index 'value' entries.
    function automatic int msf_clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/msf_bin_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : msf_bin_scheduler_if
// Description : Strobe, level and BRAM-control bundle of the bin scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface msf_bin_scheduler_if #(
    parameter int AW_S = 7,
    parameter int AW_M = 13
);
    logic            sample_valid;
    logic [15:0]     msf_level_in;
    logic            minute_sync;
    logic [15:0]     msf_level;
    logic [AW_S-1:0] addr_second;
    logic [AW_M-1:0] addr_minute;
    logic            mem_en;
    logic            mem_we;
    logic            busy;
    logic            second_tick;
    logic            minute_tick;
    logic            overrun;

    modport master (
        output sample_valid, msf_level_in, minute_sync,
        input  msf_level, addr_second, addr_minute, mem_en, mem_we,
               busy, second_tick, minute_tick, overrun
    );

    modport slave (
        input  sample_valid, msf_level_in, minute_sync,
        output msf_level, addr_second, addr_minute, mem_en, mem_we,
               busy, second_tick, minute_tick, overrun
    );
endinterface
`default_nettype wire

// File: rtl/msf_pos_counter.sv
`default_nettype none
// ============================================================================
// Module      : msf_pos_counter
// Description : Bin / second / minute-address position counters with wrap
//               ticks and synchronous zeroing on minute sync.
// Revision    : 1.0 - initial release
// ============================================================================
module msf_pos_counter
    import msf_pkg::*;
#(
    parameter int BINS_PER_SEC = 100,
    parameter int AW_S         = 7,
    parameter int AW_M         = 13
) (
    input  wire             clk,
    input  wire             reset,
    input  wire             i_advance,
    input  wire             i_zero,
    output logic [AW_S-1:0] o_bin,
    output logic [AW_M-1:0] o_min_addr,
    output logic            o_second_tick,
    output logic            o_minute_tick
);

    localparam logic [AW_S-1:0] c_BIN_LAST = AW_S'(BINS_PER_SEC - 1);
    localparam logic [5:0]      c_SEC_LAST = 6'(MSF_SECS_PER_MIN - 1);

    logic [5:0] r_sec;
    logic       w_bin_last;
    logic       w_sec_last;

    assign w_bin_last = (o_bin == c_BIN_LAST);
    assign w_sec_last = (r_sec == c_SEC_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_bin         <= '0;
            r_sec         <= '0;
            o_min_addr    <= '0;
            o_second_tick <= 1'b0;
            o_minute_tick <= 1'b0;
        end else begin
            o_second_tick <= 1'b0;
            o_minute_tick <= 1'b0;
            if (i_advance) begin
                if (w_bin_last) begin
                    o_bin         <= '0;
                    o_second_tick <= 1'b1;
                    if (w_sec_last) begin
                        r_sec         <= '0;
                        o_min_addr    <= '0;
                        o_minute_tick <= 1'b1;
                    end else begin
                        r_sec      <= r_sec + 6'd1;
                        o_min_addr <= o_min_addr + AW_M'(1);
                    end
                end else begin
                    o_bin      <= o_bin + AW_S'(1);
                    o_min_addr <= o_min_addr + AW_M'(1);
                end
            end
            // Zeroing follows the advance so a coincident wrap still ticks.
            if (i_zero) begin
                o_bin      <= '0;
                r_sec      <= '0;
                o_min_addr <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/msf_bin_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : msf_bin_scheduler
// Description : Per-bin read-modify-write sequencer for the MSF second and
//               minute level memories.
// Revision    : 1.0 - initial release
// ============================================================================
module msf_bin_scheduler
    import msf_pkg::*;
#(
    parameter int BINS_PER_SEC = 100,
    parameter int RD_LAT       = 2,
    parameter int AW_S         = 7,
    parameter int AW_M         = 13
) (
    input  wire                clk,
    input  wire                reset,
    msf_bin_scheduler_if.slave bus
);

    localparam int         c_MIN_BINS  = MSF_SECS_PER_MIN * BINS_PER_SEC;
    localparam logic [1:0] c_WAIT_LOAD = 2'(RD_LAT - 1);

    if (RD_LAT < 1 || RD_LAT > 4) begin : g_chk_rd_lat
        $error("msf_bin_scheduler: RD_LAT must be 1..4");
    end
    if (AW_S < msf_clog2(BINS_PER_SEC)) begin : g_chk_aw_s
        $error("msf_bin_scheduler: AW_S too narrow for BINS_PER_SEC");
    end
    if (AW_M < msf_clog2(c_MIN_BINS)) begin : g_chk_aw_m
        $error("msf_bin_scheduler: AW_M too narrow for one minute of bins");
    end

    msf_state_t  r_state, w_state_nxt;
    logic [1:0]  r_wait_cnt, w_wait_cnt_nxt;
    logic        r_mem_en, r_mem_we, r_busy, r_overrun, r_sync_pend;
    logic [15:0] r_level;
    logic        w_accept, w_drop, w_sync_apply;

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_accept       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.sample_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                w_state_nxt    = ST_WAIT;
                w_wait_cnt_nxt = c_WAIT_LOAD;
            end
            ST_WAIT: begin
                if (r_wait_cnt == 2'd0) begin
                    w_state_nxt = ST_CALC;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt - 2'd1;
                end
            end
            ST_CALC:  w_state_nxt = ST_WRITE;
            ST_WRITE: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_drop       = bus.sample_valid && (r_state != ST_IDLE);
    // Sync lands on the edge leaving WRITE (entering IDLE) or any idle edge.
    assign w_sync_apply = (r_sync_pend || bus.minute_sync) &&
                          ((r_state == ST_IDLE) || (r_state == ST_WRITE));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_wait_cnt  <= 2'd0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_busy      <= 1'b0;
            r_level     <= 16'd0;
            r_overrun   <= 1'b0;
            r_sync_pend <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_wait_cnt  <= w_wait_cnt_nxt;
            r_mem_en    <= (w_state_nxt == ST_READ) || (w_state_nxt == ST_WRITE);
            r_mem_we    <= (w_state_nxt == ST_WRITE);
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_sync_pend <= w_sync_apply ? 1'b0 : (r_sync_pend | bus.minute_sync);
            if (w_accept) begin
                r_level <= bus.msf_level_in;
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end
        end
    end

    msf_pos_counter #(
        .BINS_PER_SEC (BINS_PER_SEC),
        .AW_S         (AW_S),
        .AW_M         (AW_M)
    ) u_pos (
        .clk           (clk),
        .reset         (reset),
        .i_advance     (r_state == ST_WRITE),
        .i_zero        (w_sync_apply),
        .o_bin         (bus.addr_second),
        .o_min_addr    (bus.addr_minute),
        .o_second_tick (bus.second_tick),
        .o_minute_tick (bus.minute_tick)
    );

    assign bus.msf_level = r_level;
    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.busy      = r_busy;
    assign bus.overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_msf_bin_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_msf_bin_scheduler
// Description : Randomised self-checking bench for msf_bin_scheduler against
//               a bin-position reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_msf_bin_scheduler;

    localparam int BINS  = 100;
    localparam int RDL   = 2;
    localparam int AWS   = 7;
    localparam int AWM   = 13;
    localparam int MBINS = 60 * BINS;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    msf_bin_scheduler_if #(.AW_S(AWS), .AW_M(AWM)) bus ();

    msf_bin_scheduler #(
        .BINS_PER_SEC (BINS),
        .RD_LAT       (RDL),
        .AW_S         (AWS),
        .AW_M         (AWM)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    // Model: bins completed since reset or the last minute sync.
    int pos      = 0;
    bit exp_ovr  = 1'b0;
    int stick_cnt = 0;
    int mtick_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.sample_valid = 1'b0;
        bus.minute_sync  = 1'b0;
        bus.msf_level_in = 16'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        pos = 0; exp_ovr = 1'b0; stick_cnt = 0; mtick_cnt = 0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_en"},    32'(bus.mem_en), 0);
        check({tag, "_we"},    32'(bus.mem_we), 0);
        check({tag, "_busy"},  32'(bus.busy), 0);
        check({tag, "_stick"}, 32'(bus.second_tick), 0);
        check({tag, "_mtick"}, 32'(bus.minute_tick), 0);
        check({tag, "_ovr"},   32'(bus.overrun), 0);
        check({tag, "_lvl"},   32'(bus.msf_level), 0);
        check({tag, "_as"},    32'(bus.addr_second), 0);
        check({tag, "_am"},    32'(bus.addr_minute), 0);
    endtask

    // One full bin operation, optionally pulsing minute_sync while busy.
    task automatic strobe(input logic [15:0] lvl, input int extra, input bit sync_mid);
        int es, em, nxt;
        es = pos % BINS;
        em = pos % MBINS;
        bus.sample_valid = 1'b1;
        bus.msf_level_in = lvl;
        @(posedge clk); #1;
        bus.sample_valid = 1'b0;
        bus.msf_level_in = 16'($urandom);
        check("rd_en",   32'(bus.mem_en), 1);
        check("rd_we",   32'(bus.mem_we), 0);
        check("rd_busy", 32'(bus.busy), 1);
        check("rd_as",   32'(bus.addr_second), es);
        check("rd_am",   32'(bus.addr_minute), em);
        check("rd_lvl",  32'(bus.msf_level), 32'(lvl));
        for (int i = 0; i < RDL; i++) begin
            if (sync_mid && i == 0) bus.minute_sync = 1'b1;
            @(posedge clk); #1;
            bus.minute_sync = 1'b0;
            check("wait_en",   32'(bus.mem_en), 0);
            check("wait_busy", 32'(bus.busy), 1);
        end
        @(posedge clk); #1;
        check("calc_en", 32'(bus.mem_en), 0);
        check("calc_we", 32'(bus.mem_we), 0);
        @(posedge clk); #1;
        check("wr_en",    32'(bus.mem_en), 1);
        check("wr_we",    32'(bus.mem_we), 1);
        check("wr_as",    32'(bus.addr_second), es);
        check("wr_am",    32'(bus.addr_minute), em);
        check("wr_stick", 32'(bus.second_tick), 0);
        @(posedge clk); #1;
        nxt = pos + 1;
        check("id_busy",  32'(bus.busy), 0);
        check("id_en",    32'(bus.mem_en), 0);
        check("id_we",    32'(bus.mem_we), 0);
        check("id_stick", 32'(bus.second_tick), 32'(nxt % BINS == 0));
        check("id_mtick", 32'(bus.minute_tick), 32'(nxt % MBINS == 0));
        stick_cnt += int'(bus.second_tick);
        mtick_cnt += int'(bus.minute_tick);
        pos = sync_mid ? 0 : nxt;
        check("id_as",  32'(bus.addr_second), pos % BINS);
        check("id_am",  32'(bus.addr_minute), pos % MBINS);
        check("id_ovr", 32'(bus.overrun), 32'(exp_ovr));
        check("id_lvl", 32'(bus.msf_level), 32'(lvl));
        repeat (extra) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [15:0] lvl_a, lvl_b;

        reset = 1'b1;
        bus.sample_valid = 1'b0;
        bus.minute_sync  = 1'b0;
        bus.msf_level_in = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("rst");
        reset = 1'b0;

        // Single strobe with a known level.
        strobe(16'h1234, 0, 1'b0);

        // Full minute of strobes with random spacing, back-to-back included.
        do_reset();
        for (int k = 1; k <= MBINS; k++) begin
            strobe(16'($urandom), int'($urandom_range(0, 1)), 1'b0);
            if (k == BINS) begin
                check("sec1_ticks", stick_cnt, 1);
                check("sec1_as",    32'(bus.addr_second), 0);
                check("sec1_am",    32'(bus.addr_minute), BINS);
                check("sec1_ovr",   32'(bus.overrun), 0);
            end
        end
        check("min_sticks", stick_cnt, 60);
        check("min_mticks", mtick_cnt, 1);
        check("min_as",     32'(bus.addr_second), 0);
        check("min_am",     32'(bus.addr_minute), 0);

        // Second strobe three cycles after the first is dropped.
        do_reset();
        lvl_a = 16'($urandom);
        lvl_b = ~lvl_a;
        bus.sample_valid = 1'b1; bus.msf_level_in = lvl_a;
        @(posedge clk); #1 bus.sample_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        bus.sample_valid = 1'b1; bus.msf_level_in = lvl_b;
        @(posedge clk); #1 bus.sample_valid = 1'b0;
        check("ovr_set", 32'(bus.overrun), 1);
        check("ovr_lvl", 32'(bus.msf_level), 32'(lvl_a));
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("ovr_busy", 32'(bus.busy), 0);
        check("ovr_as",   32'(bus.addr_second), 1);
        check("ovr_lvl2", 32'(bus.msf_level), 32'(lvl_a));
        pos = 1; exp_ovr = 1'b1;
        strobe(16'($urandom), 0, 1'b0);

        // Minute sync while busy at bin 37 of second 12.
        do_reset();
        for (int k = 0; k < 12 * BINS + 37; k++) strobe(16'($urandom), 0, 1'b0);
        check("sync_pre_as", 32'(bus.addr_second), 37);
        check("sync_pre_am", 32'(bus.addr_minute), 1237);
        strobe(16'($urandom), 2, 1'b1);
        strobe(16'($urandom), 0, 1'b0);
        strobe(16'($urandom), 0, 1'b0);
        // Minute sync while idle zeroes on the next edge.
        bus.minute_sync = 1'b1;
        @(posedge clk); #1 bus.minute_sync = 1'b0;
        pos = 0;
        check("isync_as", 32'(bus.addr_second), 0);
        check("isync_am", 32'(bus.addr_minute), 0);
        strobe(16'($urandom), 0, 1'b0);

        // Reset asserted during WAIT aborts without a write.
        bus.sample_valid = 1'b1; bus.msf_level_in = 16'hBEEF;
        @(posedge clk); #1 bus.sample_valid = 1'b0;
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        check_idle_outputs("arst");
        repeat (2) begin
            @(negedge clk);
            check("arst_hold_we", 32'(bus.mem_we), 0);
        end
        @(posedge clk); #1 reset = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("arst_no_we", 32'(bus.mem_we), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
